// File: rtl/pl_hazard_ctrl.sv
// pl_hazard_ctrl: hazard/sequencing controller for the 5-stage F/D/E/M/W pipeline.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   Rs1D/Rs2D, Rs1E/Rs2E        source registers of the D and E instructions
//   RdE/RdM/RdW                 destination registers in E/M/W
//   ResultSrcE                  2'b01 marks a load in E
//   RegWriteM/RegWriteW         M/W instruction writes the register file
//   PCSrcE                      taken control transfer resolved in E
//   MemReqM, dmem_ready         M-stage data memory request and completion
//   StallF/D/E/M, FlushD/E/W    hold/clear controls of the pipeline registers
//   ForwardAE/ForwardBE         E-stage operand forwarding selects
//   mem_err                     one-cycle pulse when a memory access times out
//   stall_cnt, flush_cnt        saturating stall-cycle and branch-flush counters
module pl_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [1:0]       ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             dmem_ready,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int WC_W = $clog2(MEM_TIMEOUT);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    typedef enum logic {S_RUN, S_WAIT} state_t;

    state_t          state;
    logic [WC_W-1:0] wait_cnt;
    logic            timeout;
    logic            mem_stall;
    logic            lw_stall;

    // The timeout cycle drops the memory stall so the abandoned access leaves M.
    assign timeout   = state == S_WAIT && wait_cnt == WC_LAST;
    assign mem_stall = MemReqM && !dmem_ready && !timeout;
    assign lw_stall  = ResultSrcE == 2'b01 && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);

    always_comb begin
        ForwardAE = (RegWriteM && RdM != 5'd0 && RdM == Rs1E) ? 2'b10 :
                    (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ? 2'b01 : 2'b00;
        ForwardBE = (RegWriteM && RdM != 5'd0 && RdM == Rs2E) ? 2'b10 :
                    (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ? 2'b01 : 2'b00;
        StallF    = mem_stall || lw_stall;
        StallD    = mem_stall || lw_stall;
        StallE    = mem_stall;
        StallM    = mem_stall;
        FlushW    = mem_stall;
        // A memory stall defers both the load-use bubble and the branch flush.
        FlushD    = !mem_stall && !lw_stall && PCSrcE;
        FlushE    = !mem_stall && (lw_stall || PCSrcE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RUN;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            mem_err <= 1'b0;
            if (state == S_RUN) begin
                if (MemReqM && !dmem_ready) begin
                    state    <= S_WAIT;
                    wait_cnt <= WC_W'(1);
                end
            end else if (dmem_ready || !MemReqM) begin
                state <= S_RUN;
            end else if (timeout) begin
                state   <= S_RUN;
                mem_err <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + WC_W'(1);
            end
            if (StallF && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (PCSrcE && !mem_stall && !(&flush_cnt))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// tb_pl_hazard_ctrl: self-checking bench for pl_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_pl_hazard_ctrl;
    localparam int MT    = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]    ResultSrcE;
    logic          RegWriteM, RegWriteW, PCSrcE, MemReqM, dmem_ready;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int failures = 0;

    // Reference state: cycles the current M access has already been stalled, expected counters.
    int waited = 0;
    int m_sc = 0;
    int m_fc = 0;
    bit m_err = 0;

    pl_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .dmem_ready(dmem_ready),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic [1:0] rsrc;
        logic       rwm, rww, pcs, req, rdy;
        logic [3:0] est;   // {StallF,StallD,StallE,StallM}
        logic [2:0] efl;   // {FlushD,FlushE,FlushW}
        logic [1:0] efa, efb;
    } vec_t;

    vec_t tv[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        ResultSrcE = 2'b00;
        {RegWriteM, RegWriteW, PCSrcE, MemReqM} = '0;
        dmem_ready = 1'b1;
    endtask

    function automatic logic [1:0] fwd_exp(input logic [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        if (RegWriteM && RdM == rs) return 2'b10;
        if (RegWriteW && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit model_mem_stall();
        return MemReqM && !dmem_ready && waited < MT - 1;
    endfunction

    task automatic check_model();
        bit lw, ms;
        logic [6:0] ctl;
        lw = ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        ms = model_mem_stall();
        ctl = ms ? 7'b1111_001 : lw ? 7'b1100_010 : PCSrcE ? 7'b0000_110 : 7'b0;
        chk("rnd_ctl", 32'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}), 32'(ctl));
        chk("rnd_fwdA", 32'(ForwardAE), 32'(fwd_exp(Rs1E)));
        chk("rnd_fwdB", 32'(ForwardBE), 32'(fwd_exp(Rs2E)));
        chk("rnd_mem_err", 32'(mem_err), 32'(m_err));
        chk("rnd_stall_cnt", 32'(stall_cnt), 32'(m_sc));
        chk("rnd_flush_cnt", 32'(flush_cnt), 32'(m_fc));
    endtask

    task automatic model_tick();
        bit ms, lw;
        ms = model_mem_stall();
        lw = ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        if (MemReqM && !dmem_ready) begin
            m_err  = waited == MT - 1;
            waited = m_err ? 0 : waited + 1;
        end else begin
            m_err  = 0;
            waited = 0;
        end
        if ((ms || lw) && m_sc < CMAX) m_sc++;
        if (PCSrcE && !ms && m_fc < CMAX) m_fc++;
    endtask

    task automatic model_reset();
        waited = 0;
        m_sc = 0;
        m_fc = 0;
        m_err = 0;
    endtask

    // Entered and left on a negedge.
    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        chk("rst_flush_cnt", 32'(flush_cnt), 0);
        chk("rst_mem_err", 32'(mem_err), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_cycle();
        Rs1D = 5'($urandom_range(0, 3));
        Rs2D = 5'($urandom_range(0, 3));
        Rs1E = 5'($urandom_range(0, 3));
        Rs2E = 5'($urandom_range(0, 3));
        RdE  = 5'($urandom_range(0, 3));
        RdM  = 5'($urandom_range(0, 3));
        RdW  = 5'($urandom_range(0, 3));
        ResultSrcE = 2'($urandom_range(0, 3));
        RegWriteM  = 1'($urandom_range(0, 1));
        RegWriteW  = 1'($urandom_range(0, 1));
        PCSrcE     = ResultSrcE != 2'b01 && $urandom_range(0, 3) == 0;
        MemReqM    = $urandom_range(0, 2) != 0;
        dmem_ready = 1'($urandom_range(0, 1));
        #1 check_model();
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    initial begin
        tv[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 3'b000, 2'b10, 2'b00};
        tv[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 3'b000, 2'b01, 2'b00};
        tv[2]  = '{5'd0, 5'd0, 5'd5, 5'd5, 5'd0, 5'd5, 5'd5, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 3'b000, 2'b01, 2'b01};
        tv[3]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 3'b000, 2'b00, 2'b00};
        tv[4]  = '{5'd0, 5'd0, 5'd3, 5'd9, 5'd0, 5'd9, 5'd9, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 3'b000, 2'b00, 2'b10};
        tv[5]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1100, 3'b010, 2'b00, 2'b00};
        tv[6]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1100, 3'b010, 2'b00, 2'b00};
        tv[7]  = '{5'd0, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 3'b000, 2'b00, 2'b00};
        tv[8]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 3'b000, 2'b00, 2'b00};
        tv[9]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 3'b110, 2'b00, 2'b00};
        tv[10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, 3'b001, 2'b00, 2'b00};
        tv[11] = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 3'b001, 2'b00, 2'b00};
        tv[12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 3'b110, 2'b00, 2'b00};
        tv[13] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b000, 2'b00, 2'b00};

        idle();
        @(negedge clk);
        #1;
        chk("reset_stall_cnt", 32'(stall_cnt), 0);
        chk("reset_flush_cnt", 32'(flush_cnt), 0);
        chk("reset_mem_err", 32'(mem_err), 0);
        chk("reset_ctl", 32'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use bubble
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
        #1 chk("lw_stall", 32'({StallF, StallD, StallE, StallM, FlushE}), 32'(5'b11001));
        @(negedge clk);
        idle();
        #1 chk("lw_stall_cnt", 32'(stall_cnt), 1);
        chk("lw_released", 32'(StallF), 0);

        // Taken branch flush
        PCSrcE = 1'b1;
        #1 chk("br_flush", 32'({FlushD, FlushE, StallF}), 32'(3'b110));
        @(negedge clk);
        idle();
        #1 chk("br_flush_cnt", 32'(flush_cnt), 1);

        // Memory wait of three cycles then ready
        MemReqM = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("mw_stall", 32'({StallF, StallD, StallE, StallM, FlushW}), 32'(5'b11111));
            @(negedge clk);
        end
        dmem_ready = 1'b1;
        #1 chk("mw_release", 32'({StallF, StallD, StallE, StallM, FlushW}), 0);
        @(negedge clk);
        idle();
        #1 chk("mw_no_err", 32'(mem_err), 0);
        chk("mw_stall_cnt", 32'(stall_cnt), 4);

        // Timeout: never ready
        MemReqM = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("to_stall", 32'({StallF, StallD, StallE, StallM, FlushW}), 32'(5'b11111));
            @(negedge clk);
        end
        #1 chk("to_release", 32'({StallF, StallD, StallE, StallM, FlushW}), 0);
        @(negedge clk);
        idle();
        #1 chk("to_err_pulse", 32'(mem_err), 1);
        chk("to_stall_cnt", 32'(stall_cnt), 7);
        @(negedge clk);
        #1 chk("to_err_end", 32'(mem_err), 0);

        // Saturation of stall_cnt
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
        for (int i = 0; i < 9; i++) @(negedge clk);
        idle();
        #1 chk("sat_stall_cnt", 32'(stall_cnt), CMAX);
        @(negedge clk);

        // Reset in the middle of a wait
        MemReqM = 1'b1; dmem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mid_reset();
        for (int i = 0; i < 3; i++) begin
            #1 chk("rw_stall", 32'({StallF, StallD, StallE, StallM, FlushW}), 32'(5'b11111));
            chk("rw_no_err", 32'(mem_err), 0);
            @(negedge clk);
        end
        #1 chk("rw_timeout", 32'(StallF), 0);
        @(negedge clk);
        idle();
        @(negedge clk);

        // Combinational vector table
        for (int i = 0; i < 14; i++) begin
            {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} =
                {tv[i].rs1d, tv[i].rs2d, tv[i].rs1e, tv[i].rs2e, tv[i].rde, tv[i].rdm, tv[i].rdw};
            ResultSrcE = tv[i].rsrc;
            {RegWriteM, RegWriteW, PCSrcE, MemReqM, dmem_ready} =
                {tv[i].rwm, tv[i].rww, tv[i].pcs, tv[i].req, tv[i].rdy};
            #1;
            chk($sformatf("tv%0d_stall", i), 32'({StallF, StallD, StallE, StallM}), 32'(tv[i].est));
            chk($sformatf("tv%0d_flush", i), 32'({FlushD, FlushE, FlushW}), 32'(tv[i].efl));
            chk($sformatf("tv%0d_fwdA", i), 32'(ForwardAE), 32'(tv[i].efa));
            chk($sformatf("tv%0d_fwdB", i), 32'(ForwardBE), 32'(tv[i].efb));
            @(negedge clk);
        end

        // Randomized run against the reference model
        idle();
        mid_reset();
        for (int i = 0; i < 800; i++) begin
            if (i % 150 == 149) mid_reset();
            rand_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
